slicer_lane_arbiter: RTL
========================

# slicer_lane_arbiter

Round-robin scheduler that shares one PAM4 soft slicer among NUM_LANES equalized sample streams. It grants at most one lane per cycle and drives the slicer with the granted sample. It tracks the lane tag of every in-flight sample and returns each slicer decision (symbol, LLR magnitude, LLR sign) tagged with its lane through an output FIFO with backpressure. Placement: between the per-lane equalizer outputs and the FEC decoder's LLR input.

## Interface
- NUM_LANES, 4, number of requesting lanes (>=2)
- SIGNAL_RESOLUTION, 8, signed sample width
- LLR_RESOLUTION, 5, LLR magnitude width
- SLICER_LATENCY, 1, cycles from slc_valid high to slc_res_valid high (>=1)
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >= SLICER_LATENCY+2)
- LW (derived), max(1, clog2(NUM_LANES)), lane-id width

- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- lane_valid  in  NUM_LANES  per-lane sample valid
- lane_sample  in  NUM_LANES*SIGNAL_RESOLUTION  lane i sample at bits [i*SR +: SR], signed
- lane_ready  out  NUM_LANES  one-hot-or-zero grant
- slc_sample  out  SIGNAL_RESOLUTION  sample to slicer signal_in
- slc_valid  out  1  to slicer signal_in_valid
- slc_res_valid  in  1  slicer valid
- slc_symbol  in  2  slicer symbol_out
- slc_llr  in  LLR_RESOLUTION  slicer llr
- slc_llr_sign  in  1  slicer llr_sign
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_lane  out  LW  lane id of result
- out_symbol  out  2  symbol
- out_llr  out  LLR_RESOLUTION  LLR magnitude
- out_llr_sign  out  1  LLR sign
- err_unexpected  out  1  sticky; slicer result arrived with no tag in flight

## Operation
- Credit check: issue allowed iff fifo_count + inflight < FIFO_DEPTH. Both counts are register values from the start of the cycle; a same-cycle pop does not add credit.
- Arbitration: when issue is allowed, grant the first lane i with lane_valid[i]=1, searching ptr+1, ptr+2, … modulo NUM_LANES. lane_ready is combinational from lane_valid, ptr and the credit check. lane_ready is all-zero when no lane is valid or no credit exists.
- Accept = lane_valid[g] & lane_ready[g]. On accept, ptr <= g and inflight increments. With no accept, ptr holds.
- Lane valid/sample must stay stable until accepted. The block never depends on valid deasserting.
- Issue stage (registered):
  - On accept: slc_sample <= granted sample, slc_valid <= 1, and tag g enters the tag delay line (SLICER_LATENCY stages).
  - Otherwise slc_valid <= 0 and slc_sample holds.
- Return: on slc_res_valid, push {tag, slc_symbol, slc_llr, slc_llr_sign} into the FIFO and decrement inflight.
  - If slc_res_valid is high while the delay-line tail is invalid: set err_unexpected, drop the result, leave inflight unchanged.
  - Simultaneous accept and return: inflight unchanged.
- FIFO: out_* is the head entry, out_valid = (fifo_count != 0). Pop on out_valid & out_ready.
  - Simultaneous push and pop: count unchanged.
  - Overflow is impossible by credit. Pointers wrap modulo FIFO_DEPTH.
- Reset (rstn=0 at a clock edge), including mid-operation:
  - ptr <= NUM_LANES-1, so lane 0 has first priority.
  - inflight, fifo_count, FIFO pointers and the delay line are cleared.
  - slc_valid <= 0, slc_sample <= 0, err_unexpected <= 0.
  - out_valid is 0 and out_lane/out_symbol/out_llr/out_llr_sign read 0 (FIFO head masked while empty).
  - lane_ready is 0 during reset.
  - In-flight samples are discarded. The slicer shares rstn, so stale slicer output cannot arrive.

## Timing
- Accept in cycle t gives slc_valid=1 in t+1. The slicer result arrives in t+1+SLICER_LATENCY. out_valid rises in t+2+SLICER_LATENCY if the FIFO was empty.
- With default SLICER_LATENCY=1, accept-to-out_valid latency is 3 cycles.
- Sustained throughput is 1 sample/cycle aggregate when out_ready=1, split evenly across all continuously-valid lanes.
- A lane waits at most NUM_LANES-1 grants of other lanes once credit is available.

## Test plan
- Single lane: lane 2 presents 0x30 for one accept with out_ready=1 → slc_valid pulses with slc_sample=0x30 one cycle later; out_valid appears 3 cycles after accept with out_lane=2 and symbol/LLR equal to the slicer's.
- All four lanes continuously valid after reset → grant order 0,1,2,3,0,1,…; one accept every cycle; out_lane sequence matches.
- Lanes 1 and 3 valid only → grants alternate 1,3,1,3; lanes 0 and 2 are never granted.
- out_ready=0 with all lanes valid → exactly FIFO_DEPTH=8 accepts total, then lane_ready stays 0. Raising out_ready drains 8 results in order, and accepts resume without loss or duplication.
- rstn low for 1 cycle with 2 samples in flight and 3 in the FIFO → next cycle out_valid=0, slc_valid=0, err_unexpected=0; first post-reset grant goes to lane 0.
- Inject slc_res_valid=1 with nothing in flight → err_unexpected=1 and stays 1; fifo_count is unchanged.

Source files
------------

// File: rtl/slicer_lane_arbiter.sv
// Round-robin arbiter sharing one PAM4 soft slicer across NUM_LANES sample streams.
// Tracks in-flight lane tags and returns tagged slicer decisions through a credit-protected FIFO.
module slicer_lane_arbiter #(
    parameter int unsigned NUM_LANES         = 4,
    parameter int unsigned SIGNAL_RESOLUTION = 8,
    parameter int unsigned LLR_RESOLUTION    = 5,
    parameter int unsigned SLICER_LATENCY    = 1,
    parameter int unsigned FIFO_DEPTH        = 8,
    localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_LANES-1:0]                   lane_valid,
    input  logic [NUM_LANES*SIGNAL_RESOLUTION-1:0] lane_sample,
    output logic [NUM_LANES-1:0]                   lane_ready,
    output logic [SIGNAL_RESOLUTION-1:0]           slc_sample,
    output logic                                   slc_valid,
    input  logic                                   slc_res_valid,
    input  logic [1:0]                             slc_symbol,
    input  logic [LLR_RESOLUTION-1:0]              slc_llr,
    input  logic                                   slc_llr_sign,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [LW-1:0]                          out_lane,
    output logic [1:0]                             out_symbol,
    output logic [LLR_RESOLUTION-1:0]              out_llr,
    output logic                                   out_llr_sign,
    output logic                                   err_unexpected
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [LW-1:0]             lane;
        logic [1:0]                symbol;
        logic [LLR_RESOLUTION-1:0] llr;
        logic                      llr_sign;
    } result_t;

    logic [LW-1:0]                        ptr;
    logic [LW-1:0]                        grant_idx;
    logic                                 grant_found;
    logic                                 credit_ok;
    logic                                 accept;
    logic [SIGNAL_RESOLUTION-1:0]         grant_sample;
    logic [CW-1:0]                        inflight;
    logic [CW-1:0]                        fifo_count;
    logic [LW-1:0]                        slc_tag;
    logic [SLICER_LATENCY-1:0]            dl_vld;
    logic [SLICER_LATENCY-1:0][LW-1:0]    dl_tag;
    logic                                 tail_vld;
    logic [LW-1:0]                        tail_tag;
    logic                                 push;
    logic                                 pop;
    logic [AW-1:0]                        wr_ptr;
    logic [AW-1:0]                        rd_ptr;
    result_t                              mem [FIFO_DEPTH];
    result_t                              head;

    // Credit counts both queued and in-flight results so the FIFO can never overflow.
    assign credit_ok = ((CW+1)'(fifo_count) + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);

    // Round-robin search starting one past the last granted lane.
    always_comb begin
        int unsigned   cand;
        logic [LW-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 1; k <= NUM_LANES; k++) begin
            cand     = (32'(ptr) + k) % NUM_LANES;
            cand_idx = LW'(cand);
            if (!grant_found && lane_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        lane_ready = '0;
        if (rstn && credit_ok && grant_found) begin
            lane_ready[grant_idx] = 1'b1;
        end
    end

    assign accept       = |lane_ready;
    assign grant_sample = lane_sample[32'(grant_idx)*SIGNAL_RESOLUTION +: SIGNAL_RESOLUTION];

    assign tail_vld = dl_vld[SLICER_LATENCY-1];
    assign tail_tag = dl_tag[SLICER_LATENCY-1];
    assign push     = slc_res_valid & tail_vld;
    assign pop      = out_valid & out_ready;

    // Head is masked while empty so the outputs read zero after reset.
    assign out_valid    = (fifo_count != '0);
    assign head         = out_valid ? mem[rd_ptr] : '0;
    assign out_lane     = head.lane;
    assign out_symbol   = head.symbol;
    assign out_llr      = head.llr;
    assign out_llr_sign = head.llr_sign;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr            <= LW'(NUM_LANES - 1);
            inflight       <= '0;
            slc_valid      <= 1'b0;
            slc_sample     <= '0;
            slc_tag        <= '0;
            dl_vld         <= '0;
            dl_tag         <= '0;
            err_unexpected <= 1'b0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            slc_valid <= accept;
            if (accept) begin
                ptr        <= grant_idx;
                slc_sample <= grant_sample;
                slc_tag    <= grant_idx;
            end

            // Tag delay line lines up with the slicer result SLICER_LATENCY cycles after issue.
            dl_vld <= SLICER_LATENCY'({dl_vld, slc_valid});
            dl_tag <= (SLICER_LATENCY*LW)'({dl_tag, slc_tag});

            if (accept && !push) begin
                inflight <= inflight + CW'(1);
            end else if (!accept && push) begin
                inflight <= inflight - CW'(1);
            end

            if (slc_res_valid && !tail_vld) begin
                err_unexpected <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Result storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{lane: tail_tag, symbol: slc_symbol, llr: slc_llr, llr_sign: slc_llr_sign};
        end
    end

endmodule
